// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle HI/LO multiply/divide unit for the EX stage
module mult_div_unit #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic [31:0]    hi_q, hi_d, lo_q, lo_d;
  logic [31:0]    pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic           pend_ok_q, pend_ok_d;

  logic [63:0]        prod_s, prod_u;
  logic               div_ovf;
  logic [31:0]        dvsr_s, dvsr_u, quot_u, rem_u;
  logic signed [31:0] quot_s, rem_s;

  // Divisor is forced to 1 for B=0 and for the INT_MIN/-1 overflow so the
  // dividers never produce X; the overflow case then yields A, 0 naturally.
  always_comb begin
    prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u  = {32'd0, A} * {32'd0, B};
    div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    dvsr_s  = ((B == 32'd0) || div_ovf) ? 32'd1 : B;
    dvsr_u  = (B == 32'd0) ? 32'd1 : B;
    quot_s  = $signed(A) / $signed(dvsr_s);
    rem_s   = $signed(A) % $signed(dvsr_s);
    quot_u  = A / dvsr_u;
    rem_u   = A % dvsr_u;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdop)
            3'd0, 3'd1: begin
              {pend_hi_d, pend_lo_d} = (mdop == 3'd0) ? prod_s : prod_u;
              pend_ok_d = 1'b1;
              cnt_d     = CW'(MULT_CYC);
              busy_d    = 1'b1;
              state_d   = RUN;
            end
            3'd2, 3'd3: begin
              pend_hi_d = (mdop == 3'd2) ? rem_s  : rem_u;
              pend_lo_d = (mdop == 3'd2) ? quot_s : quot_u;
              pend_ok_d = (B != 32'd0);
              cnt_d     = CW'(DIV_CYC);
              busy_d    = 1'b1;
              state_d   = RUN;
            end
            3'd4:    hi_d = A;
            3'd5:    lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (pend_ok_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdop = 3'd7;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO;

  int total = 0;
  int bad = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .mdop(mdop),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdop = op; A = a; B = b; start = 1'b1;
    step();
    start = 1'b0; mdop = 3'd7;
  endtask

  // Counts sampled busy cycles (bounded) and notes whether HI/LO moved early.
  task automatic wait_commit(output int n, output bit stable);
    logic [31:0] h, l;
    h = HI; l = LO; n = 0; stable = 1'b1;
    while (busy === 1'b1 && n < 50) begin
      n++;
      if (HI !== h || LO !== l) stable = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle%0d got HI=%h LO=%h busy=%b exp 0/0/0", i, HI, LO, busy);
      end
    end
  endtask

  task automatic test_mult();
    int n; bit st;
    launch(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_commit(n, st);
    total++; if (n !== 5) begin bad++; $display("FAIL mult_busy got=%0d exp=5", n); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL mult_early got=%b exp=1", st); end
    total++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      bad++; $display("FAIL mult_res got=%h_%h exp=ffffffff_fffffffa", HI, LO); end
  endtask

  task automatic test_multu();
    int n; bit st;
    launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_commit(n, st);
    total++; if (n !== 5 || st !== 1'b1) begin
      bad++; $display("FAIL multu_busy got=%0d stable=%b exp=5/1", n, st); end
    total++; if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
      bad++; $display("FAIL multu_res got=%h_%h exp=fffffffe_00000001", HI, LO); end
  endtask

  task automatic test_div();
    int n; bit st;
    launch(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_commit(n, st);
    total++; if (n !== 10 || st !== 1'b1) begin
      bad++; $display("FAIL div_busy got=%0d stable=%b exp=10/1", n, st); end
    total++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      bad++; $display("FAIL div_res got=%h_%h exp=ffffffff_fffffffd", HI, LO); end
    launch(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_commit(n, st);
    total++; if (n !== 10 || HI !== 32'd0 || LO !== 32'h8000_0000) begin
      bad++; $display("FAIL div_ovf got=%0d %h_%h exp=10 00000000_80000000", n, HI, LO); end
    launch(3'd3, 32'd100, 32'd7);
    wait_commit(n, st);
    total++; if (n !== 10 || HI !== 32'd2 || LO !== 32'd14) begin
      bad++; $display("FAIL divu_res got=%0d %h_%h exp=10 00000002_0000000e", n, HI, LO); end
  endtask

  task automatic test_div_zero();
    int n; bit st;
    launch(3'd4, 32'h11, 32'd0);
    launch(3'd5, 32'h22, 32'd0);
    total++; if (HI !== 32'h11 || LO !== 32'h22 || busy !== 1'b0) begin
      bad++; $display("FAIL mthi_mtlo got=%h_%h busy=%b exp=11_22 0", HI, LO, busy); end
    launch(3'd3, 32'd7, 32'd0);
    wait_commit(n, st);
    total++; if (n !== 10) begin bad++; $display("FAIL divz_busy got=%0d exp=10", n); end
    total++; if (HI !== 32'h11 || LO !== 32'h22) begin
      bad++; $display("FAIL divz_keep got=%h_%h exp=11_22", HI, LO); end
    launch(3'd6, 32'h5, 32'h5);
    total++; if (HI !== 32'h11 || LO !== 32'h22 || busy !== 1'b0) begin
      bad++; $display("FAIL nop got=%h_%h busy=%b exp=11_22 0", HI, LO, busy); end
  endtask

  task automatic test_control_abort();
    bit quiet;
    launch(3'd4, 32'hDEAD_BEEF, 32'd0);
    total++; if (HI !== 32'hDEAD_BEEF || LO !== 32'h22 || busy !== 1'b0) begin
      bad++; $display("FAIL mthi got=%h_%h busy=%b exp=deadbeef_22 0", HI, LO, busy); end
    launch(3'd2, 32'd100, 32'd7);
    step();
    mdop = 3'd5; A = 32'h55; start = 1'b1;
    step();
    start = 1'b0; mdop = 3'd7;
    total++; if (LO !== 32'h22 || busy !== 1'b1) begin
      bad++; $display("FAIL mtlo_in_run got LO=%h busy=%b exp=22 1", LO, busy); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL abort got=%h_%h busy=%b exp=0_0 0", HI, LO, busy); end
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) quiet = 1'b0;
    end
    total++; if (quiet !== 1'b1) begin
      bad++; $display("FAIL abort_late got=%h_%h busy=%b exp=0_0 0", HI, LO, busy); end
  endtask

  task automatic test_back_to_back();
    int n; bit st;
    launch(3'd0, 32'd6, 32'd7);
    for (int i = 0; i < 4; i++) step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_pre got=%b exp=1", busy); end
    mdop = 3'd4; A = 32'h99; start = 1'b1;
    step();
    start = 1'b0; mdop = 3'd7;
    total++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd42) begin
      bad++; $display("FAIL b2b_commit got=%h_%h busy=%b exp=0_2a 0", HI, LO, busy); end
    launch(3'd1, 32'd3, 32'd4);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart got=%b exp=1", busy); end
    wait_commit(n, st);
    total++; if (n !== 5 || st !== 1'b1 || HI !== 32'd0 || LO !== 32'd12) begin
      bad++; $display("FAIL b2b_res got=%0d %b %h_%h exp=5 1 0_c", n, st, HI, LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_control_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core. It sits beside the ALU.
- It takes the same forwarded A/B operands from the ID/EX register. It supplies HI/LO, which the EX-stage result mux selects for mfhi/mflo.
- It executes mult, multu, div, divu, mthi and mtlo. It exposes busy so the hazard unit can stall later HI/LO users.

Parameters:
- MULT_CYC, 5, cycles from the start edge to the HI/LO commit for mult/multu (>=1).
- DIV_CYC, 10, cycles from the start edge to the HI/LO commit for div/divu (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; the instruction in EX is an MD operation.
- mdop  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- busy  output  1  high while a mult/div is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- One clock; reset is synchronous and active-high on clk/reset.
- On reset: HI=0, LO=0, busy=0, cycle counter=0, pending result cleared. Reset during an operation aborts it with no commit.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter loaded with MULT_CYC or DIV_CYC).
- IDLE -> RUN:
  - Trigger: posedge with start=1 and mdop in 0..3.
  - At that edge, latch the operation result into internal pending registers; the result is computed from A/B sampled at that edge.
  - Load the counter with N = MULT_CYC or DIV_CYC.
- RUN:
  - Counter decrements each edge.
  - On the N-th edge after the start edge, HI/LO take the pending result, busy falls at the same edge, and the state returns to IDLE.
  - busy is therefore high for exactly N cycles.
  - HI/LO keep their old values throughout RUN.
- mult: {HI,LO} = signed(A)*signed(B), full 64 bits.
- multu: {HI,LO} = unsigned(A)*unsigned(B), full 64 bits.
- div: LO = signed quotient, truncated toward zero; HI = remainder, which carries the sign of the dividend A.
  - Overflow case: A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: LO = A/B, HI = A%B, both unsigned.
- Divide by zero (div/divu with B=0):
  - The unit still runs DIV_CYC cycles with busy.
  - At commit, HI/LO keep their previous values; no X may propagate.
- mthi / mtlo:
  - When start=1 in IDLE, HI (resp. LO) takes A at that same edge.
  - busy stays 0 and the other register is unchanged.
- mdop 6/7 with start=1: no state change.
- start while busy=1: ignored entirely, including mthi/mtlo. The hazard unit guarantees this does not happen; the bench checks that it is ignored.
- Back-to-back operation:
  - start may be asserted in the cycle immediately after busy falls.
  - A new start on the commit edge itself is ignored, because busy is still 1 during that cycle.
- Stall contract for the hazard unit:
  - Stall any MD-class instruction in ID while (start | busy).
  - The unit itself never reads a stall input.
- HI/LO are registered outputs only; there is no combinational path from A/B to HI/LO.

Test Plan:
- Reset, then idle 3 cycles -> HI=0, LO=0, busy=0 throughout.
- mult A=0xFFFFFFFE (-2), B=3 ->
  - busy=1 for exactly 5 cycles.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA on the 5th edge.
  - HI/LO unchanged before that edge.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- div A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7, B=0 with prior HI=0x11, LO=0x22 -> busy for 10 cycles, then HI=0x11, LO=0x22 (unchanged).
- Control and abort sequence:
  - mthi A=0xDEADBEEF -> HI=0xDEADBEEF next edge, busy stays 0.
  - Then start div, and assert mtlo start mid-run -> the mtlo is ignored.
  - Assert reset in run cycle 4 -> HI=LO=0, busy=0, no later commit.
